// File: rtl/gyro_heading_integrator.sv
// Single-axis gyro heading integrator: calibrates a rate offset, then integrates
// offset-compensated (optionally IR-fused) rate into a signed heading.
`timescale 1ns/1ps

module gyro_heading_integrator #(
    parameter int unsigned RATE_W    = 16,
    parameter int unsigned FUS_W     = 9,
    parameter int unsigned CAL_LOG2  = 11,
    parameter int unsigned HEAD_W    = 12,
    parameter int unsigned FRAC      = 15,
    parameter int unsigned FUS_SHIFT = 7,
    parameter int unsigned WRAP      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              strt_cal,
    input  logic              clr_hdg,
    input  logic              vld,
    input  logic [RATE_W-1:0] yaw_rt,
    input  logic [FUS_W-1:0]  IR_Dtrm,
    input  logic              moving,
    input  logic              en_fusion,
    output logic              cal_busy,
    output logic              cal_done,
    output logic              rdy,
    output logic [HEAD_W-1:0] heading,
    output logic [RATE_W-1:0] offset
);

    localparam int unsigned INT_W  = HEAD_W + FRAC;
    localparam int unsigned SUM_W  = INT_W + 1;
    localparam int unsigned COMP_W = RATE_W + 1;
    localparam int unsigned ACC_W  = RATE_W + CAL_LOG2;
    localparam int unsigned CNT_W  = CAL_LOG2 + 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1) << CAL_LOG2;
    localparam logic [INT_W-1:0] INT_MAX  = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic [INT_W-1:0] INT_MIN  = {1'b1, {(INT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CAL, RUN} state_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_CAL, TAG_RUN} tag_t;

    state_t                    state, state_nxt;
    logic                      cal_fin;
    tag_t                      tag1;
    logic signed [COMP_W-1:0]  s1;
    logic signed [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]          cnt;
    logic signed [INT_W-1:0]   integ;
    logic signed [SUM_W-1:0]   fus;
    logic signed [SUM_W-1:0]   sum;
    logic [INT_W-1:0]          integ_upd;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state; restart has priority over completion
    always_comb begin
        state_nxt = state;
        cal_fin   = 1'b0;
        case (state)
            IDLE: if (strt_cal) state_nxt = CAL;
            CAL: begin
                if (strt_cal) begin
                    state_nxt = CAL;
                end else if (cnt == CNT_FULL) begin
                    state_nxt = RUN;
                    cal_fin   = 1'b1;
                end
            end
            RUN: if (strt_cal) state_nxt = CAL;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage 1: capture and tag the sample with the state it belongs to
    always_ff @(posedge clk) begin
        if (rst) begin
            tag1 <= TAG_NONE;
            s1   <= '0;
        end else begin
            tag1 <= TAG_NONE;
            if (vld && !strt_cal && !cal_fin) begin
                if (state == RUN) begin
                    tag1 <= TAG_RUN;
                    s1   <= COMP_W'($signed(yaw_rt)) - COMP_W'($signed(offset));
                end else if (state == CAL) begin
                    tag1 <= TAG_CAL;
                    s1   <= COMP_W'($signed(yaw_rt));
                end
            end
        end
    end

    // Integrator next value, wrapping or saturating
    always_comb begin
        fus = '0;
        if (en_fusion) fus = SUM_W'($signed(IR_Dtrm)) <<< FUS_SHIFT;
        sum = SUM_W'(integ) + SUM_W'(s1) - fus;
        integ_upd = sum[INT_W-1:0];
        if (WRAP == 0 && (sum[SUM_W-1] != sum[SUM_W-2]))
            integ_upd = sum[SUM_W-1] ? INT_MIN : INT_MAX;
    end

    // Stage 2: calibration accumulation, integration and completion
    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            cnt      <= '0;
            integ    <= '0;
            offset   <= '0;
            cal_done <= 1'b0;
            cal_busy <= 1'b0;
            rdy      <= 1'b0;
        end else begin
            cal_done <= 1'b0;
            rdy      <= 1'b0;
            cal_busy <= (state_nxt == CAL);
            if (strt_cal) begin
                acc   <= '0;
                cnt   <= '0;
                integ <= '0;
            end else if (cal_fin) begin
                offset   <= RATE_W'(acc >>> CAL_LOG2);
                integ    <= '0;
                cal_done <= 1'b1;
            end else begin
                if (tag1 == TAG_CAL && state == CAL && cnt != CNT_FULL) begin
                    acc <= acc + ACC_W'(s1);
                    cnt <= cnt + CNT_W'(1);
                end
                if (tag1 == TAG_RUN) begin
                    rdy <= 1'b1;
                    if (moving) integ <= integ_upd;
                end
                if (clr_hdg) integ <= '0;
            end
        end
    end

    assign heading = integ[INT_W-1 -: HEAD_W];

endmodule

// File: tb/tb_gyro_heading_integrator.sv
// Scoreboard bench: two instances (wrap and saturate) share stimulus; a monitor
// checks every rdy against queued expectations.
`timescale 1ns/1ps

module tb_gyro_heading_integrator;

    logic        clk = 1'b0;
    logic        rst, strt_cal, clr_hdg, vld, moving, en_fusion;
    logic [15:0] yaw_rt;
    logic [8:0]  ir_dtrm;

    logic        cal_busy_w, cal_done_w, rdy_w;
    logic [11:0] heading_w;
    logic [15:0] offset_w;
    logic        cal_busy_s, cal_done_s, rdy_s;
    logic [11:0] heading_s;
    logic [15:0] offset_s;

    gyro_heading_integrator #(.CAL_LOG2(3), .WRAP(1)) dut_w (
        .clk(clk), .rst(rst), .strt_cal(strt_cal), .clr_hdg(clr_hdg), .vld(vld),
        .yaw_rt(yaw_rt), .IR_Dtrm(ir_dtrm), .moving(moving), .en_fusion(en_fusion),
        .cal_busy(cal_busy_w), .cal_done(cal_done_w), .rdy(rdy_w),
        .heading(heading_w), .offset(offset_w)
    );

    gyro_heading_integrator #(.CAL_LOG2(3), .WRAP(0)) dut_s (
        .clk(clk), .rst(rst), .strt_cal(strt_cal), .clr_hdg(clr_hdg), .vld(vld),
        .yaw_rt(yaw_rt), .IR_Dtrm(ir_dtrm), .moving(moving), .en_fusion(en_fusion),
        .cal_busy(cal_busy_s), .cal_done(cal_done_s), .rdy(rdy_s),
        .heading(heading_s), .offset(offset_s)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int at;
        int hw;
        int hs;
    } exp_t;

    exp_t   sb[$];
    exp_t   mon_e;
    int     errors = 0;
    int     checks = 0;
    int     cal_done_cnt = 0;
    int     rdy_in_cal = 0;
    longint mi_w = 0;
    longint mi_s = 0;
    int     off_m = 0;
    bit     run_mode = 0;

    task automatic check(string name, longint act, longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic longint wrap27(longint v);
        longint m;
        m = v & ((longint'(1) << 27) - 1);
        if (m >= (longint'(1) << 26)) m = m - (longint'(1) << 27);
        return m;
    endfunction

    function automatic longint sat27(longint v);
        if (v > (longint'(1) << 26) - 1) return (longint'(1) << 26) - 1;
        if (v < -(longint'(1) << 26)) return -(longint'(1) << 26);
        return v;
    endfunction

    // Reference integrator; pushes the expected heading for a RUN sample
    task automatic model_step(int y, int at, bit clr);
        longint comp, f;
        if (!run_mode) return;
        comp = longint'(y) - longint'(off_m);
        f = en_fusion ? longint'($signed(ir_dtrm)) * 128 : 0;
        if (moving) begin
            mi_w = wrap27(mi_w + comp - f);
            mi_s = sat27(mi_s + comp - f);
        end
        if (clr) begin
            mi_w = 0;
            mi_s = 0;
        end
        sb.push_back('{at, int'(mi_w >>> 15), int'(mi_s >>> 15)});
    endtask

    task automatic send(int y);
        @(posedge clk); #1;
        vld = 1'b1;
        yaw_rt = 16'(y);
        model_step(y, cyc + 2, 1'b0);
    endtask

    task automatic quiet(int n);
        repeat (n) begin
            @(posedge clk); #1;
            vld = 1'b0;
            strt_cal = 1'b0;
            clr_hdg = 1'b0;
        end
    endtask

    task automatic send_clr(int y);
        int c;
        @(posedge clk); #1;
        c = cyc;
        vld = 1'b1;
        yaw_rt = 16'(y);
        @(posedge clk); #1;
        vld = 1'b0;
        clr_hdg = 1'b1;
        model_step(y, c + 2, 1'b1);
        @(posedge clk); #1;
        clr_hdg = 1'b0;
    endtask

    task automatic start_cal(bit with_vld, int y, int old_off);
        @(posedge clk); #1;
        strt_cal = 1'b1;
        vld = with_vld;
        yaw_rt = 16'(y);
        run_mode = 0;
        @(negedge clk);
        check("cal_busy_before_edge", cal_busy_w, 0);
        @(posedge clk); #1;
        strt_cal = 1'b0;
        vld = 1'b0;
        @(negedge clk);
        check("cal_busy_after_start", cal_busy_w, 1);
        check("heading_cleared_on_start", $signed(heading_w), 0);
        check("offset_held_in_cal", $signed(offset_w), old_off);
    endtask

    task automatic wait_cal(int exp_off);
        bit ok;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cal_done_w) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL cal_done_timeout: no cal_done within 40 cycles (cycle %0d)", cyc);
        end else begin
            check("cal_busy_at_done", cal_busy_w, 0);
            check("cal_done_sat_inst", cal_done_s, 1);
            check("offset_after_cal", $signed(offset_w), exp_off);
            check("heading_after_cal", $signed(heading_w), 0);
        end
        off_m = exp_off;
        mi_w = 0;
        mi_s = 0;
        run_mode = 1;
    endtask

    task automatic drain(int maxc);
        bit ok;
        ok = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL rdy_timeout: %0d expected samples never reported", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: every rdy must match the oldest queued expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (cal_done_w) cal_done_cnt++;
            if (rdy_w && cal_busy_w) rdy_in_cal++;
            if (rdy_w || rdy_s) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rdy: rdy_w=%0d rdy_s=%0d with no sample pending (cycle %0d)",
                             rdy_w, rdy_s, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("rdy_latency", cyc, mon_e.at);
                    check("rdy_w", rdy_w, 1);
                    check("rdy_s", rdy_s, 1);
                    check("heading_wrap", $signed(heading_w), mon_e.hw);
                    check("heading_sat", $signed(heading_s), mon_e.hs);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; strt_cal = 1'b0; clr_hdg = 1'b0; vld = 1'b0;
        moving = 1'b0; en_fusion = 1'b0; yaw_rt = '0; ir_dtrm = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_heading", heading_w, 0);
        check("reset_offset", offset_w, 0);
        check("reset_cal_busy", cal_busy_w, 0);
        check("reset_cal_done", cal_done_w, 0);
        check("reset_rdy", rdy_w, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        quiet(2);

        // Calibration: 8 gapped samples of 100
        start_cal(1'b0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            send(100);
            quiet(1);
        end
        wait_cal(100);

        // Integration: comp = 4096, 8 back-to-back -> integ 32768, heading 1
        moving = 1'b1;
        for (int i = 0; i < 8; i++) send(4196);
        quiet(1);
        drain(10);
        check("heading_after_integration", $signed(heading_w), 1);

        // Fusion: comp 0, IR_Dtrm 1 -> -128 per sample
        en_fusion = 1'b1;
        ir_dtrm = 9'(1);
        for (int i = 0; i < 3; i++) send(100);
        quiet(1);
        drain(10);
        check("heading_after_fusion", $signed(heading_w), 0);

        // Not moving: no change, rdy still pulses
        moving = 1'b0;
        send(5000);
        send(-3000);
        quiet(1);
        drain(10);

        moving = 1'b1;
        en_fusion = 1'b0;
        for (int i = 0; i < 8; i++) send(4196);
        quiet(1);
        drain(10);
        check("heading_before_clear", $signed(heading_w), 1);

        // Clear coincident with a stage-2 update
        send_clr(4196);
        drain(10);
        check("heading_after_clear", $signed(heading_w), 0);
        check("offset_kept_after_clear", $signed(offset_w), 100);

        for (int i = 0; i < 8; i++) send(4196);
        quiet(1);
        drain(10);
        check("heading_before_restart", $signed(heading_w), 1);

        // Restart with coincident vld (dropped), then back-to-back floor test
        start_cal(1'b1, -1000, 100);
        for (int i = 0; i < 7; i++) send(-1);
        send(0);
        quiet(1);
        wait_cal(-1);

        // Saturation vs wrap with zero offset
        start_cal(1'b0, 0, -1);
        for (int i = 0; i < 8; i++) send(0);
        quiet(1);
        wait_cal(0);
        for (int i = 0; i < 2060; i++) send(32767);
        quiet(1);
        drain(20);
        check("sat_heading_final", $signed(heading_s), 2047);
        check("wrap_heading_final", $signed(heading_w), -2037);

        check("cal_done_count", cal_done_cnt, 3);
        check("rdy_during_cal", rdy_in_cal, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
